// File: rtl/audio_serial_rx.sv
// ---------------------------------------------------------------------------
// audio_serial_rx
//
// Receives an I2S-style serial audio stream from a codec and presents complete
// left/right sample pairs in the system clock domain. The codec signals are
// asynchronous to clk_i. They are synchronized and then sampled only on
// detected bit-clock rising edges.
//
// Ports
//   clk_i         system clock, all state on its rising edge
//   rst_i         asynchronous active-high reset
//   bclk_i        codec bit clock (asynchronous)
//   lrck_i        codec word select, 0 = left slot, 1 = right slot (async)
//   sdata_i       codec serial data, MSB first (async)
//   out_l_o       last complete left sample
//   out_r_o       last complete right sample
//   new_sample_o  one-clk pulse when out_l_o/out_r_o are updated
//   frame_err_o   one-clk pulse when a slot ends before WIDTH bits arrived
// ---------------------------------------------------------------------------
module audio_serial_rx #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bclk_i,
    input  logic             lrck_i,
    input  logic             sdata_i,
    output logic [WIDTH-1:0] out_l_o,
    output logic [WIDTH-1:0] out_r_o,
    output logic             new_sample_o,
    output logic             frame_err_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    // Synchronizer chains: meta -> sync -> dly
    logic bclkMeta_q, bclkSync_q, bclkDly_q;
    logic lrckMeta_q, lrckSync_q, lrckDly_q;
    logic sdataMeta_q, sdataSync_q, sdataDly_q;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;
    logic             slotCh_q, slotCh_d;
    logic             lrckPrev_q, lrckPrev_d;
    logic             lrckPrimed_q, lrckPrimed_d;
    logic [WIDTH-1:0] holdL_q, holdL_d;
    logic [WIDTH-1:0] holdR_q, holdR_d;
    logic             leftValid_q, leftValid_d;
    logic             rightDone_q, rightDone_d;
    logic             frameErr_q, frameErr_d;
    logic [WIDTH-1:0] outL_q, outR_q;
    logic             newSample_q;

    logic             bclkRise;
    logic             slotStart;
    logic [WIDTH-1:0] shiftIn;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bclkMeta_q  <= 1'b0;
            bclkSync_q  <= 1'b0;
            bclkDly_q   <= 1'b0;
            lrckMeta_q  <= 1'b0;
            lrckSync_q  <= 1'b0;
            lrckDly_q   <= 1'b0;
            sdataMeta_q <= 1'b0;
            sdataSync_q <= 1'b0;
            sdataDly_q  <= 1'b0;
        end else begin
            bclkMeta_q  <= bclk_i;
            bclkSync_q  <= bclkMeta_q;
            bclkDly_q   <= bclkSync_q;
            lrckMeta_q  <= lrck_i;
            lrckSync_q  <= lrckMeta_q;
            lrckDly_q   <= lrckSync_q;
            sdataMeta_q <= sdata_i;
            sdataSync_q <= sdataMeta_q;
            sdataDly_q  <= sdataSync_q;
        end
    end

    // lrck/sdata are taken from their third stage, i.e. one clk before the
    // bit-clock edge became visible, so they are well inside the codec's
    // stable window around its rising edge.
    assign bclkRise  = bclkSync_q & ~bclkDly_q;
    assign slotStart = bclkRise & lrckPrimed_q & (lrckDly_q != lrckPrev_q);
    assign shiftIn   = {shift_q[WIDTH-2:0], sdataDly_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= SYNC;
            shift_q      <= '0;
            bitCnt_q     <= '0;
            slotCh_q     <= 1'b0;
            lrckPrev_q   <= 1'b0;
            lrckPrimed_q <= 1'b0;
            holdL_q      <= '0;
            holdR_q      <= '0;
            leftValid_q  <= 1'b0;
            rightDone_q  <= 1'b0;
            frameErr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitCnt_q     <= bitCnt_d;
            slotCh_q     <= slotCh_d;
            lrckPrev_q   <= lrckPrev_d;
            lrckPrimed_q <= lrckPrimed_d;
            holdL_q      <= holdL_d;
            holdR_q      <= holdR_d;
            leftValid_q  <= leftValid_d;
            rightDone_q  <= rightDone_d;
            frameErr_q   <= frameErr_d;
        end
    end

    // The first bit-clock rise after reset only records the current lrck
    // level (lrckPrimed), so a slot already in progress at reset release is
    // never mistaken for a slot boundary.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitCnt_d     = bitCnt_q;
        slotCh_d     = slotCh_q;
        lrckPrev_d   = lrckPrev_q;
        lrckPrimed_d = lrckPrimed_q;
        holdL_d      = holdL_q;
        holdR_d      = holdR_q;
        leftValid_d  = leftValid_q;
        rightDone_d  = 1'b0;
        frameErr_d   = 1'b0;

        if (bclkRise) begin
            lrckPrev_d   = lrckDly_q;
            lrckPrimed_d = 1'b1;

            unique case (state_q)
                SYNC: begin
                    if (slotStart) begin
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    // A slot that ends on its delay bit carries no data.
                    if (slotStart) begin
                        frameErr_d = 1'b1;
                    end else begin
                        state_d  = SHIFT;
                        bitCnt_d = '0;
                    end
                end
                SHIFT: begin
                    if (slotStart) begin
                        frameErr_d = 1'b1;
                        state_d    = DELAY;
                    end else begin
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q + 1'b1;
                        if (bitCnt_q == CW'(WIDTH - 1)) begin
                            state_d = PAD;
                            if (slotCh_q == 1'b0) begin
                                holdL_d     = shiftIn;
                                leftValid_d = 1'b1;
                            end else begin
                                holdR_d     = shiftIn;
                                rightDone_d = leftValid_q;
                                leftValid_d = 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (slotStart) begin
                        state_d = DELAY;
                    end
                end
                default: state_d = SYNC;
            endcase

            // A new left slot invalidates any older left word, so a pair is
            // only ever formed from adjacent left and right slots.
            if (slotStart) begin
                slotCh_d = lrckDly_q;
                if (lrckDly_q == 1'b0) begin
                    leftValid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outL_q      <= '0;
            outR_q      <= '0;
            newSample_q <= 1'b0;
        end else begin
            newSample_q <= rightDone_q;
            if (rightDone_q) begin
                outL_q <= holdL_q;
                outR_q <= holdR_q;
            end
        end
    end

    assign out_l_o      = outL_q;
    assign out_r_o      = outR_q;
    assign new_sample_o = newSample_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: tb/tb_audio_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_audio_serial_rx
//
// Drives a simulated codec (bclk at 1/4 of clk) into audio_serial_rx. Each
// slot is laid out as: bit 0 = first bit with the new lrck level, bit 1 =
// delay bit, bits 2..WIDTH+1 = sample MSB first, remaining bits = random pad.
// Expected sample pairs are queued before the right slot is sent and are
// popped and compared whenever new_sample pulses.
// ---------------------------------------------------------------------------
module tb_audio_serial_rx;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         bclk;
    logic         lrck;
    logic         sdata;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
    logic         new_sample;
    logic         frame_err;

    int    checks       = 0;
    int    failures     = 0;
    int    cyc          = 0;
    int    errCount     = 0;
    int    pulseCount   = 0;
    int    lastPulseCyc = 0;
    int    lsbRiseCyc   = 0;
    pair_t expQ[$];
    pair_t popped;

    audio_serial_rx #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bclk_i       (bclk),
        .lrck_i       (lrck),
        .sdata_i      (sdata),
        .out_l_o      (out_l),
        .out_r_o      (out_r),
        .new_sample_o (new_sample),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: every new_sample pulse must match the oldest queued pair.
    always @(negedge clk) begin
        if (frame_err) errCount++;
        if (new_sample) begin
            pulseCount++;
            lastPulseCyc = cyc;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: got out_l=%h out_r=%h, required no pulse", out_l, out_r);
            end else begin
                popped = expQ.pop_front();
                checks++;
                if (out_l !== popped.l) begin
                    failures++;
                    $display("[TB] FAIL sb_out_l: got %h, required %h", out_l, popped.l);
                end
                checks++;
                if (out_r !== popped.r) begin
                    failures++;
                    $display("[TB] FAIL sb_out_r: got %h, required %h", out_r, popped.r);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One codec bit: falling edge with new lrck/sdata, rising edge 2 clk later.
    task automatic send_bit(input logic ch, input logic d, input bit markLsb);
        @(posedge clk);
        @(posedge clk);
        #3;
        bclk  = 1'b0;
        lrck  = ch;
        sdata = d;
        @(posedge clk);
        @(posedge clk);
        #3;
        bclk = 1'b1;
        if (markLsb) lsbRiseCyc = cyc;
    endtask

    task automatic send_slot(input logic ch, input logic [W-1:0] word, input int nData,
                             input int firstIdx, input int lastIdx);
        logic d;
        for (int i = firstIdx; i < lastIdx; i++) begin
            if (i >= 2 && i < 2 + nData) d = word[W + 1 - i];
            else                         d = 1'($urandom_range(0, 1));
            send_bit(ch, d, (ch == 1'b1) && (nData == W) && (i == W + 1));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int rBits, input bit expectPulse);
        pair_t p;
        send_slot(1'b0, l, W, 0, 32);
        if (expectPulse) begin
            p.l = l;
            p.r = r;
            expQ.push_back(p);
        end
        if (rBits == W) send_slot(1'b1, r, W, 0, 32);
        else            send_slot(1'b1, r, rBits, 0, 2 + rBits);
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d expected pulses missing, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        bclk  = 1'b0;
        lrck  = 1'b0;
        sdata = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_l !== '0) begin failures++; $display("[TB] FAIL reset_out_l: got %h, required 0", out_l); end
        checks++;
        if (out_r !== '0) begin failures++; $display("[TB] FAIL reset_out_r: got %h, required 0", out_r); end
        checks++;
        if (new_sample !== 1'b0) begin failures++; $display("[TB] FAIL reset_new_sample: got %b, required 0", new_sample); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b, required 0", frame_err); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic_frames();
        int e0 = errCount;
        int p0 = pulseCount;
        send_frame(24'h000003, 24'h00BEEF, W, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(24'h000003, 24'h00BEEF, W, 1'b1);
        #1;
        checks++;
        if (out_l !== 24'h000003) begin failures++; $display("[TB] FAIL basic_out_l: got %h, required 000003", out_l); end
        checks++;
        if (out_r !== 24'h00BEEF) begin failures++; $display("[TB] FAIL basic_out_r: got %h, required 00beef", out_r); end
        checks++;
        if (pulseCount - p0 != 3) begin failures++; $display("[TB] FAIL basic_pulses: got %0d, required 3", pulseCount - p0); end
        checks++;
        if (errCount - e0 != 0) begin failures++; $display("[TB] FAIL basic_frame_err: got %0d, required 0", errCount - e0); end
        check_queue_empty("basic_queue");
    endtask

    task automatic test_latency();
        send_frame(24'h0A0B0C, 24'h0D0E0F, W, 1'b1);
        checks++;
        if (lastPulseCyc - lsbRiseCyc != 4) begin
            failures++;
            $display("[TB] FAIL latency: got %0d clk, required 4", lastPulseCyc - lsbRiseCyc);
        end
        check_queue_empty("latency_queue");
    endtask

    task automatic test_truncated_right();
        int e0;
        send_frame(24'h111111, 24'h222222, W, 1'b1);
        e0 = errCount;
        send_frame(24'h333333, 24'h444444, 16, 1'b0);
        #1;
        checks++;
        if (out_l !== 24'h111111) begin failures++; $display("[TB] FAIL trunc_hold_l: got %h, required 111111", out_l); end
        checks++;
        if (out_r !== 24'h222222) begin failures++; $display("[TB] FAIL trunc_hold_r: got %h, required 222222", out_r); end
        send_frame(24'h555555, 24'h666666, W, 1'b1);
        #1;
        checks++;
        if (errCount - e0 != 1) begin failures++; $display("[TB] FAIL trunc_frame_err: got %0d pulses, required 1", errCount - e0); end
        checks++;
        if (out_r !== 24'h666666) begin failures++; $display("[TB] FAIL trunc_recover_r: got %h, required 666666", out_r); end
        check_queue_empty("trunc_queue");
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        send_slot(1'b0, 24'hAAAAAA, W, 0, 32);
        send_slot(1'b1, 24'hBBBBBB, W, 0, 10);
        rst = 1'b1;
        #3;
        bclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_l !== '0 || out_r !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got %h/%h, required 0/0", out_l, out_r);
        end
        rst = 1'b0;
        p0 = pulseCount;
        send_slot(1'b1, 24'hBBBBBB, W, 10, 32);
        checks++;
        if (pulseCount != p0) begin failures++; $display("[TB] FAIL midreset_no_pulse: got %0d pulses, required 0", pulseCount - p0); end
        send_frame(24'h123456, 24'h654321, W, 1'b1);
        #1;
        checks++;
        if (pulseCount - p0 != 1) begin failures++; $display("[TB] FAIL midreset_first_pair: got %0d pulses, required 1", pulseCount - p0); end
        check_queue_empty("midreset_queue");
    endtask

    task automatic test_back_to_back_ramp();
        int p0 = pulseCount;
        for (int f = 0; f < 8; f++) send_frame(24'h000003, 24'h00BEEF + 24'(3 * f), W, 1'b1);
        #1;
        checks++;
        if (pulseCount - p0 != 8) begin failures++; $display("[TB] FAIL ramp_pulses: got %0d, required 8", pulseCount - p0); end
        checks++;
        if (out_r !== 24'h00BF04) begin failures++; $display("[TB] FAIL ramp_last_r: got %h, required 00bf04", out_r); end
        check_queue_empty("ramp_queue");
    endtask

    task automatic test_msb_pad();
        int e0 = errCount;
        for (int f = 0; f < 2; f++) send_frame(24'h800001, 24'hFFFFFF, W, 1'b1);
        #1;
        checks++;
        if (out_l !== 24'h800001) begin failures++; $display("[TB] FAIL pad_out_l: got %h, required 800001", out_l); end
        checks++;
        if (out_r !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL pad_out_r: got %h, required ffffff", out_r); end
        checks++;
        if (errCount != e0) begin failures++; $display("[TB] FAIL pad_frame_err: got %0d, required 0", errCount - e0); end
        check_queue_empty("pad_queue");
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_latency();
        test_truncated_right();
        test_reset_mid_frame();
        test_back_to_back_ramp();
        test_msb_pad();
        repeat (8) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_serial_rx.md
AUDIO_SERIAL_RX -- requirements
Module: audio_serial_rx

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set the sample width per channel in bits.
REQ-002 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 bclk  input  1  serial bit clock from the codec, asynchronous to clk.
REQ-005 lrck  input  1  word select, asynchronous to clk; 0 = left slot, 1 = right slot.
REQ-006 sdata  input  1  serial data, MSB first, asynchronous to clk.
REQ-007 out_l  output  WIDTH  last complete left sample.
REQ-008 out_r  output  WIDTH  last complete right sample.
REQ-009 new_sample  output  1  one-clk pulse when out_l/out_r are updated; feeds the audio_manip new_sample input.
REQ-010 frame_err  output  1  one-clk pulse when a slot ends with fewer than WIDTH bits.

Function
REQ-011 bclk, lrck and sdata SHALL each pass through a 2-flop synchronizer, with one further registered stage for edge detection.
REQ-012 A bclk rise SHALL be detected when the synchronized bclk is 1 and its delayed copy is 0; it is the only event that samples lrck and sdata.
REQ-013 Operating range: clk frequency at least 4x bclk; behaviour below that is undefined.
REQ-014 FSM states: SYNC, DELAY, SHIFT, PAD.
REQ-015 SYNC: the first lrck change seen on a bclk rise SHALL go to DELAY; no data is captured before this.
REQ-016 DELAY: the bit on the next bclk rise SHALL be discarded (I2S one-bit delay); then go to SHIFT with bit count cleared.
REQ-017 SHIFT: each bclk rise SHALL shift sdata into a WIDTH-bit shift register, MSB first, and increment the bit count.
REQ-018 When the count reaches WIDTH, the word SHALL be stored in the holding register for the slot's channel (lrck value at slot start), and the FSM goes to PAD.
REQ-019 PAD: extra slot bits (e.g. 32-bit slots) SHALL be ignored; an lrck change on a bclk rise SHALL go to DELAY.
REQ-020 An lrck change in SHIFT before WIDTH bits SHALL discard the partial word, pulse frame_err the next clk, and go to DELAY for the new slot.
REQ-021 Completing a right word SHALL, on the next clk, load out_l from the left holding register and out_r from the right word, with new_sample=1 for exactly that cycle.
REQ-022 new_sample SHALL NOT assert unless a valid left word was captured in the immediately preceding left slot; a discarded left or right slot suppresses that frame's pulse.
REQ-023 out_l/out_r SHALL hold their value between new_sample pulses.
REQ-024 Latency: new_sample SHALL assert exactly 4 clk after the codec bclk rising edge carrying the right LSB (2 sync + 1 edge + 1 output register).
REQ-025 Back-to-back frames SHALL produce one new_sample per frame with no lost frame.

Reset
REQ-026 While rst=1: out_l=0, out_r=0, new_sample=0, frame_err=0, FSM=SYNC, shift register, bit count, holding registers, left-valid flag and all synchronizer flops = 0.
REQ-027 Reset mid-frame SHALL abandon the partial frame; after release, capture resumes only at the next lrck change (SYNC).

Verification
REQ-028 Reset, then 64-bclk I2S frames with left=24'h000003, right=24'h00BEEF (clk=4x bclk) -> after the first full frame, out_l=24'h000003, out_r=24'h00BEEF, one new_sample pulse per frame, frame_err never asserts.
REQ-029 Release reset mid-right-slot -> no new_sample until a complete left+right pair is received; the first pulse carries that pair's values.
REQ-030 Right slot cut to 16 bits -> frame_err pulses once, no new_sample that frame, out_l/out_r keep previous values; the next good frame updates normally.
REQ-031 Ramp right sample +3 per frame from 24'h00BEEF over 8 frames -> out_r sequence 00BEEF, 00BEF2, ... 00BF04 with no skips.
REQ-032 Left=24'h800001, right=24'hFFFFFF with random sdata in pad bits -> exact MSB-first capture, pad bits ignored.
REQ-033 Count clk from the bclk rise carrying the right LSB to the new_sample rise -> exactly 4.
